fifo_word_serializer: RTL and testbench
=======================================

Name: fifo_word_serializer

Overview:
Downstream consumer of the synchronous word FIFO. It pops WIDTH-bit words from the FIFO and emits each one as a sequence of narrower OUT_WIDTH-bit beats on a valid/ready stream, for example to feed a byte-wide UART or SPI transmitter. It drives the FIFO's get strobe directly and relies on the FIFO read data being combinational from the read pointer, so the word is valid whenever empty is low.

Parameters:
WIDTH, 32, FIFO word width in bits; must equal the upstream FIFO's WIDTH.
OUT_WIDTH, 8, output beat width; WIDTH/OUT_WIDTH must be an integer power of two (1 allowed).
MSB_FIRST, 0, 0 = least-significant beat sent first; 1 = most-significant beat first.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO head word, valid when fifo_empty=0
fifo_get  output  1  pop strobe to FIFO; one-cycle pulse per word
out_data  output  OUT_WIDTH  current beat
out_valid  output  1  beat valid
out_ready  input  1  sink accepts beat
out_last  output  1  high with the final beat of each word
busy  output  1  high while a word is held (state SEND)

Behaviour:
- Derived constants: BEATS = WIDTH/OUT_WIDTH; CW = max(1, log2(BEATS)).
- State register has two states, IDLE and SEND, plus a WIDTH-bit shift register sh and a CW-bit beat counter bc.
- Reset: state=IDLE, sh=0, bc=0, out_valid=0, out_last=0, busy=0. fifo_get is forced to 0 while rst is high. Reset mid-word discards the partial word; the FIFO is not re-popped.
- Handshake: a beat transfers on a rising edge where out_valid and out_ready are both 1. While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- load = (state==IDLE && !fifo_empty) || (state==SEND && out_ready && bc==BEATS-1 && !fifo_empty).
- fifo_get = load. It is combinational and may depend on out_ready in the same cycle. On the edge where fifo_get=1, sh captures fifo_data.
- IDLE: out_valid=0. If fifo_empty=0, go to SEND with bc=0. The first beat appears on out_data one cycle after the fifo_get pulse.
- SEND: out_valid=1 and busy=1.
  - out_data = sh[OUT_WIDTH-1:0] when MSB_FIRST=0, otherwise sh[WIDTH-1:WIDTH-OUT_WIDTH].
  - On each transfer, sh shifts by OUT_WIDTH toward the output end and bc increments.
  - out_last = (bc==BEATS-1).
- Last-beat transfer: bc wraps to 0 naturally because BEATS is a power of two. If fifo_empty=0, the next word loads in the same cycle and the state stays SEND, giving zero-bubble back-to-back streaming. Otherwise the state returns to IDLE.
- BEATS==1: every beat has out_last=1. The block acts as a one-word register stage with pop-on-accept.
- Throughput: one beat per cycle when out_ready=1 and data is available. Per word, the pop occurs at most once, exactly on the load edge.
- fifo_empty toggling while in SEND has no effect until a last-beat transfer.
- The block never pops when fifo_empty=1 and never double-pops a word.

Decomposition:
- Shared package: BEATS/CW derivation functions, the state encoding constants (IDLE=0, SEND=1), and an elaboration-time check that WIDTH%OUT_WIDTH==0 and BEATS is a power of two.
- Sub-module: the beat counter is an instance of the existing up_counter (WIDTH=CW, en = transfer, rst shared). No other sub-modules.

Test Plan:
- Defaults; FIFO holds 0xA1B2C3D4; out_ready=1 -> one fifo_get pulse; beats D4,C3,B2,A1 on 4 consecutive cycles starting 1 cycle after the pop; out_last only with A1; back to IDLE.
- Two words 0x11223344 and 0x55667788 queued; out_ready=1 -> 8 consecutive beats with no bubble; second fifo_get coincides with the 0x11 transfer cycle.
- Backpressure: out_ready=0 for 3 cycles during beat 2 -> out_data=0xC3 and out_last=0 held stable; no pop; resume completes the word correctly.
- MSB_FIRST=1, word 0xA1B2C3D4 -> beats A1,B2,C3,D4 with out_last on D4.
- Reset asserted after beat 2 of 0xA1B2C3D4 -> out_valid=0 immediately (asynchronous); after release, the block pops the next FIFO word and bc starts at 0.
- FIFO empty for 20 cycles -> fifo_get=0 and out_valid=0 throughout. With OUT_WIDTH=32, a single word yields one beat with out_last=1.

Source files
------------

// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and helpers for the FIFO word serializer.
// Holds the state encoding and the beat-count derivations.
package fifo_word_serializer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic int calc_beats(input int w, input int ow);
      return w / ow;
   endfunction

   function automatic int calc_cw(input int beats);
      int c;
      c = $clog2(beats);
      return (c < 1) ? 1 : c;
   endfunction

   // Word must split into a power-of-two number of beats so the
   // beat counter wraps to zero on its own after the last beat.
   function automatic bit cfg_ok(input int w, input int ow);
      int b;
      if (ow <= 0 || w < ow) return 1'b0;
      if ((w % ow) != 0) return 1'b0;
      b = w / ow;
      return (b & (b - 1)) == 0;
   endfunction

endpackage

// File: rtl/fifo_word_serializer_up_counter.sv
// Free-running up counter with enable and synchronous clear.
// Ports: clk, rst (async high), en, clr, count.
module up_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO and streams them out as narrower beats.
// Ports: clk, rst (async high); FIFO side fifo_empty/fifo_data/
// fifo_get; stream side out_data/out_valid/out_ready/out_last;
// busy is high while a word is held.
module fifo_word_serializer
   import fifo_word_serializer_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_data,
   output logic                 fifo_get,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   localparam int BEATS = calc_beats(WIDTH, OUT_WIDTH);
   localparam int CW    = calc_cw(BEATS);
   localparam logic [CW-1:0] LAST_BC = CW'(BEATS - 1);

   generate
      if (!cfg_ok(WIDTH, OUT_WIDTH)) begin : g_cfg_err
         $error("fifo_word_serializer: bad WIDTH/OUT_WIDTH ratio");
      end
   endgenerate

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] sh_d;
   logic [CW-1:0]    bc;
   logic             transfer;
   logic             last_beat;
   logic             load;

   assign transfer  = (state_q == SEND) && out_ready;
   assign last_beat = (bc == LAST_BC);

   // Next word loads either from idle or on the final-beat
   // handshake, which gives gap-free word-to-word streaming.
   assign load = ((state_q == IDLE) && !fifo_empty) ||
                 (transfer && last_beat && !fifo_empty);

   assign fifo_get = load && !rst;

   // Clear on the last beat: matches natural wrap for BEATS>1 and
   // keeps a one-bit counter at zero when BEATS==1.
   up_counter #(
      .WIDTH (CW)
   ) u_bc (
      .clk   (clk),
      .rst   (rst),
      .en    (transfer),
      .clr   (transfer && last_beat),
      .count (bc)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      if (load) begin
         sh_d = fifo_data;
      end else if (transfer) begin
         if (MSB_FIRST) begin
            sh_d = sh_q << OUT_WIDTH;
         end else begin
            sh_d = sh_q >> OUT_WIDTH;
         end
      end
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = SEND;
         end
         SEND: begin
            if (transfer && last_beat && fifo_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
      end
   end

   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign out_last  = (state_q == SEND) && last_beat;
   assign out_data  = MSB_FIRST ? sh_q[WIDTH-1 -: OUT_WIDTH]
                                : sh_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: FIFO model, beat scoreboard,
// vector table and hand sequences for stall, reset, MSB-first.
module tb_fifo_word_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_data  = '0;
   logic        fifo_get;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;

   logic        s_empty;
   logic [31:0] s_data;
   logic        s_ready;
   logic        m_get, m_valid, m_last, m_busy;
   logic [7:0]  m_data;
   logic        w_get, w_valid, w_last, w_busy;
   logic [31:0] w_data;

   fifo_word_serializer u_dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_get   (fifo_get),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   fifo_word_serializer #(.MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (s_empty),
      .fifo_data  (s_data),
      .fifo_get   (m_get),
      .out_data   (m_data),
      .out_valid  (m_valid),
      .out_ready  (s_ready),
      .out_last   (m_last),
      .busy       (m_busy)
   );

   fifo_word_serializer #(.OUT_WIDTH(32)) u_w32 (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (s_empty),
      .fifo_data  (s_data),
      .fifo_get   (w_get),
      .out_data   (w_data),
      .out_valid  (w_valid),
      .out_ready  (s_ready),
      .out_last   (w_last),
      .busy       (w_busy)
   );

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [31:0] w;
      logic [7:0]  b0, b1, b2, b3;
   } vec_t;

   beat_t       exp_q[$];
   logic [31:0] fq[$];
   int          n_vec   = 0;
   int          n_err   = 0;
   int          pop_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, req);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3);
      fq.push_back(w);
      exp_q.push_back('{d: b0, l: 1'b0});
      exp_q.push_back('{d: b1, l: 1'b0});
      exp_q.push_back('{d: b2, l: 1'b0});
      exp_q.push_back('{d: b3, l: 1'b1});
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      #1;
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   // FIFO model: pop on the edge where get is high, head visible
   // shortly after each rising edge.
   always @(posedge clk) begin
      if (fifo_get && fq.size() > 0) fq.delete(0);
      #1;
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() > 0) ? fq[0] : 32'h0;
   end

   // Scoreboard monitor, sampled just before each rising edge.
   always @(negedge clk) begin
      beat_t e;
      #4;
      if (!rst) begin
         if (fifo_get) begin
            pop_cnt++;
            chk("get_nonempty", 32'(fifo_empty), 32'd0);
            if (busy) chk("get_on_last", 32'({out_ready, out_last}), 32'd3);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_beat: got %h, want none", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 32'(out_data), 32'(e.d));
               chk("beat_last", 32'(out_last), 32'(e.l));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[4];
      logic [7:0] msb_exp[4];
      int         p0;
      int         run;
      bit         started;

      tbl[0] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      tbl[2] = '{32'h01020304, 8'h04, 8'h03, 8'h02, 8'h01};
      tbl[3] = '{32'h800000FF, 8'hFF, 8'h00, 8'h00, 8'h80};
      msb_exp[0] = 8'hA1;
      msb_exp[1] = 8'hB2;
      msb_exp[2] = 8'hC3;
      msb_exp[3] = 8'hD4;

      rst       = 1'b1;
      out_ready = 1'b0;
      s_empty   = 1'b1;
      s_data    = 32'hA1B2C3D4;
      s_ready   = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_get", 32'(fifo_get), 32'd0);

      // Word waiting in FIFO while reset held: no pop allowed.
      push_word(32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
      @(negedge clk);
      #1;
      chk("rst_get_full", 32'(fifo_get), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      p0  = pop_cnt;
      #4;
      chk("lat_get", 32'(fifo_get), 32'd1);
      chk("lat_valid0", 32'(out_valid), 32'd0);
      @(negedge clk);
      #4;
      chk("lat_valid1", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'hD4);
      chk("lat_get1", 32'(fifo_get), 32'd0);
      @(negedge clk);
      drain();
      chk("pops_first", 32'(pop_cnt - p0), 32'd1);

      for (int i = 0; i < 4; i++) begin
         p0 = pop_cnt;
         push_word(tbl[i].w, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3);
         @(negedge clk);
         drain();
         chk("pops_vec", 32'(pop_cnt - p0), 32'd1);
      end

      // Two words back to back: eight beats, no bubble.
      p0 = pop_cnt;
      push_word(32'h11223344, 8'h44, 8'h33, 8'h22, 8'h11);
      push_word(32'h55667788, 8'h88, 8'h77, 8'h66, 8'h55);
      run     = 0;
      started = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #4;
         if (out_valid && out_ready) begin
            started = 1'b1;
            run++;
         end else if (started) begin
            break;
         end
      end
      chk("b2b_run", 32'(run), 32'd8);
      @(negedge clk);
      drain();
      chk("pops_b2b", 32'(pop_cnt - p0), 32'd2);

      // Backpressure on the second beat with a word queued behind.
      push_word(32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
      push_word(32'h0A0B0C0D, 8'h0D, 8'h0C, 8'h0B, 8'h0A);
      for (int i = 0; i < 40 && exp_q.size() != 7; i++) @(negedge clk);
      chk("bp_reach", 32'(exp_q.size()), 32'd7);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #4;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'hC3);
         chk("bp_last", 32'(out_last), 32'd0);
         chk("bp_get", 32'(fifo_get), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      drain();

      // Reset after two beats: partial word dropped, next word sent.
      p0 = pop_cnt;
      push_word(32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
      push_word(32'h55667788, 8'h88, 8'h77, 8'h66, 8'h55);
      for (int i = 0; i < 40 && exp_q.size() != 6; i++) @(negedge clk);
      chk("mr_reach", 32'(exp_q.size()), 32'd6);
      rst = 1'b1;
      #1;
      chk("mr_valid", 32'(out_valid), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_get", 32'(fifo_get), 32'd0);
      chk("mr_fifo", 32'(fq.size()), 32'd1);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      @(negedge clk);
      rst = 1'b0;
      drain();
      chk("pops_mr", 32'(pop_cnt - p0), 32'd2);

      // Empty FIFO: nothing happens.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #4;
         chk("empty_get", 32'(fifo_get), 32'd0);
         chk("empty_valid", 32'(out_valid), 32'd0);
      end

      // MSB-first and single-beat instances share one word.
      @(negedge clk);
      s_empty = 1'b0;
      #4;
      chk("msb_get", 32'(m_get), 32'd1);
      chk("w32_get", 32'(w_get), 32'd1);
      @(negedge clk);
      s_empty = 1'b1;
      #4;
      chk("w32_valid", 32'(w_valid), 32'd1);
      chk("w32_data", w_data, 32'hA1B2C3D4);
      chk("w32_last", 32'(w_last), 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #4;
         end
         chk("msb_valid", 32'(m_valid), 32'd1);
         chk("msb_data", 32'(m_data), 32'(msb_exp[k]));
         chk("msb_last", 32'(m_last), (k == 3) ? 32'd1 : 32'd0);
         if (k == 1) chk("w32_done", 32'(w_valid), 32'd0);
      end
      @(negedge clk);
      #4;
      chk("msb_idle", 32'(m_busy), 32'd0);
      chk("msb_get_end", 32'(m_get), 32'd0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
